sync_fifo: RTL

//  Single-clock parametrised FIFO with integrated storage, occupancy count,

---
 rtl/sync_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a selectable standard or fall-through read port.
module sync_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 3,
   parameter int FWFT         = 0,
   parameter int AFULL_LEVEL  = 6,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                  DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

   // Handshake: r_en is a pop request, honoured only when not empty. In
   // fall-through mode r_valid/r_en act as valid/acknowledge: the head word is
   // consumed on a clock edge where both are high. A write into a full FIFO is
   // honoured only when a pop is honoured in the same cycle.
   assign rd_acc = r_en & ~empty;
   assign wr_acc = w_en & (~full | rd_acc);

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + PTR_ONE;
         2'b01:   count_nxt = count - PTR_ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         count        <= count_nxt;
         almost_full  <= (count_nxt >= AFULL_CNT);
         almost_empty <= (count_nxt <= AEMPTY_CNT);
         overflow     <= w_en & ~wr_acc;
         underflow    <= r_en & empty;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= w_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign r_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
         assign r_valid = ~empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_data_q;
         logic                  r_valid_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_data_q  <= '0;
               r_valid_q <= 1'b0;
            end else begin
               if (rd_acc) r_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
               r_valid_q <= rd_acc;
            end
         end

         assign r_data  = r_data_q;
         assign r_valid = r_valid_q;
      end
   endgenerate

endmodule
